snake_step_ctrl: RTL
====================

SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 The block SHALL expose the following parameters (name, default, meaning):
- XW, 6, cell-x width.
- YW, 5, cell-y width.
- GRID_W, 40, columns.
- GRID_H, 30, rows.
- MAX_LEN, 128, body capacity.
- INIT_LEN, 3, segments after start.
- START_X, 10, initial head x.
- START_Y, 15, initial head y.

REQ-002 The block SHALL expose the following ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset_n, in, 1, synchronous active-low reset.
- start, in, 1, pulse; (re)starts a game from IDLE or DEAD.
- tick, in, 1, one-cycle game-step strobe.
- dir_req, in, 2, requested direction: 0 up, 1 right, 2 down, 3 left.
- food_x, in, XW, food cell x.
- food_y, in, YW, food cell y.
- body_len, in, 8, current body length.
- scan_data, in, XW+YW, body segment at scan_addr; valid one cycle after the address.
- body_clr, out, 1, one-cycle clear of body storage.
- body_push, out, 1, insert body_din as new head.
- body_pop, out, 1, drop tail.
- body_din, out, XW+YW, {x,y} written on push.
- scan_addr, out, 8, body index to read.
- head_x, out, XW, current head x.
- head_y, out, YW, current head y.
- busy, out, 1, step in progress.
- food_eaten, out, 1, one-cycle pulse.
- step_done, out, 1, one-cycle pulse.
- game_over, out, 1, level.
- tick_overrun, out, 1, sticky flag.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, INIT, WAIT, CALC, SCAN, COMMIT, DEAD; after reset the state SHALL be IDLE.

REQ-004 A start pulse in IDLE or DEAD SHALL enter CLEAR, which SHALL assert body_clr for exactly one cycle, clear game_over and tick_overrun, and set the current direction to right.

REQ-005 INIT SHALL push INIT_LEN segments on consecutive cycles:
- Coordinates (START_X-INIT_LEN+1+k, START_Y) for k=0..INIT_LEN-1, so the last segment pushed is the head.
- body_pop SHALL be 0 throughout INIT.
- head_x/head_y SHALL equal (START_X, START_Y) on entering WAIT.

REQ-006 In WAIT, a tick SHALL latch dir_req unless it is the exact reverse of the current direction, in which case the current direction is kept; the FSM SHALL then go to CALC.

REQ-007 CALC (one cycle) SHALL compute the next head as head ±1 in x or y.
- Underflow below 0, or x ≥ GRID_W, or y ≥ GRID_H, SHALL go to DEAD with no push or pop.
- Width-limited wrap SHALL NOT be accepted as a legal move.

REQ-008 CALC SHALL set grow = (next head == {food_x,food_y}) && (body_len < MAX_LEN).
- Scan count N SHALL be body_len if grow, else body_len-1, because the tail vacates the cell.

REQ-009 SCAN SHALL drive scan_addr = i on SCAN cycle i, for i = 0..N-1.
- It SHALL compare scan_data to the next head one cycle later.
- Any match SHALL go to DEAD with no push or pop.
- With N=0, SCAN SHALL last one cycle and detect no collision.

REQ-010 COMMIT (one cycle) SHALL assert body_push with body_din = next head, and SHALL assert body_pop = !grow.
- It SHALL update head_x/head_y and pulse step_done.
- It SHALL pulse food_eaten if the next head equals the food cell, including at MAX_LEN, where the move is push+pop and the snake does not grow.
- The FSM SHALL then return to WAIT.

REQ-011 Step latency from the tick cycle to the COMMIT cycle SHALL be 3 + N cycles.
- busy SHALL be 1 in every state except IDLE, WAIT and DEAD.

REQ-012 A tick arriving in CLEAR, INIT, CALC, SCAN or COMMIT SHALL be dropped and SHALL set tick_overrun until the next start.

REQ-013 Ticks in IDLE or DEAD SHALL be ignored without setting tick_overrun.

REQ-014 A start pulse in any state other than IDLE or DEAD SHALL be ignored.

REQ-015 body_push, body_pop, body_clr, food_eaten and step_done SHALL never be asserted outside the states given above.

REQ-016 DEAD SHALL hold game_over=1 and freeze head_x/head_y until start.

Reset
REQ-017 With reset_n=0 at a clock edge, the block SHALL:
- enter IDLE;
- drive all pulse outputs and busy, game_over and tick_overrun to 0;
- set head_x=START_X, head_y=START_Y, direction right, scan_addr=0, body_din=0.

REQ-018 Reset SHALL take precedence over every input, including mid-SCAN and mid-INIT.
- No push or pop SHALL be issued in the cycle after reset is released.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- Start -> body_clr for 1 cycle, then 3 pushes of (8,15),(9,15),(10,15); WAIT with head (10,15), busy=0.
- Tick with dir_req=1, body_len=3, no food -> N=2, COMMIT 5 cycles after the tick with push+pop, din=(11,15), step_done pulse.
- Food at (11,15), tick right -> push only, no pop, food_eaten pulse, N=3.
- Direction right, dir_req=3 (left) -> reversal rejected, head moves to (11,15).
- Head at (39,y), tick right -> DEAD, game_over=1, no push or pop.
- Snake whose next head equals body index 2 -> DEAD after compare.
- Moving into the current tail cell (non-grow) -> legal, no death.
- Tick during SCAN -> tick_overrun=1, step result unchanged.
- reset_n low during SCAN -> IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/snake_step_ctrl.sv
// Snake game step controller: builds the initial body, then on each tick
// computes the next head, scans the body for collisions and commits the move.
module snake_step_ctrl #(
    parameter int XW       = 6,
    parameter int YW       = 5,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 128,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 10,
    parameter int START_Y  = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               tick,
    input  logic [1:0]         dir_req,
    input  logic [XW-1:0]      food_x,
    input  logic [YW-1:0]      food_y,
    input  logic [7:0]         body_len,
    input  logic [XW+YW-1:0]   scan_data,
    output logic               body_clr,
    output logic               body_push,
    output logic               body_pop,
    output logic [XW+YW-1:0]   body_din,
    output logic [7:0]         scan_addr,
    output logic [XW-1:0]      head_x,
    output logic [YW-1:0]      head_y,
    output logic               busy,
    output logic               food_eaten,
    output logic               step_done,
    output logic               game_over,
    output logic               tick_overrun
);

    localparam int CW = XW + YW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_INIT   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_CALC   = 3'd4;
    localparam logic [2:0] S_SCAN   = 3'd5;
    localparam logic [2:0] S_COMMIT = 3'd6;
    localparam logic [2:0] S_DEAD   = 3'd7;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;

    localparam logic [XW:0]   GRID_W_L  = (XW+1)'(GRID_W);
    localparam logic [YW:0]   GRID_H_L  = (YW+1)'(GRID_H);
    localparam logic [XW:0]   X_ONE     = (XW+1)'(1);
    localparam logic [YW:0]   Y_ONE     = (YW+1)'(1);
    localparam logic [8:0]    MAX_LEN_L = 9'(MAX_LEN);
    localparam logic [7:0]    INIT_LAST = 8'(INIT_LEN - 1);
    localparam logic [XW-1:0] INIT_X0   = XW'(START_X - INIT_LEN + 1);
    localparam logic [XW-1:0] START_X_L = XW'(START_X);
    localparam logic [YW-1:0] START_Y_L = YW'(START_Y);

    logic [2:0]    state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [XW-1:0] head_x_q, head_x_d;
    logic [YW-1:0] head_y_q, head_y_d;
    logic [CW-1:0] nxt_q, nxt_d;
    logic          grow_q, grow_d;
    logic          eat_q, eat_d;
    logic [7:0]    scan_n_q, scan_n_d;
    logic [7:0]    scan_idx_q, scan_idx_d;
    logic          cmp_vld_q, cmp_vld_d;
    logic [7:0]    init_cnt_q, init_cnt_d;
    logic          overrun_q, overrun_d;

    logic [XW:0]   cand_x;
    logic [YW:0]   cand_y;
    logic          off_grid;
    logic [CW-1:0] next_xy;
    logic          hit_food;
    logic          grow_c;
    logic [7:0]    scan_len_c;

    // Candidate head is one bit wider so a step past the last column/row is
    // seen as off-grid rather than silently wrapping.
    always_comb begin
        cand_x   = {1'b0, head_x_q};
        cand_y   = {1'b0, head_y_q};
        off_grid = 1'b0;
        case (dir_q)
            DIR_UP: begin
                off_grid = (head_y_q == '0);
                cand_y   = cand_y - Y_ONE;
            end
            DIR_RIGHT: begin
                cand_x   = cand_x + X_ONE;
                off_grid = (cand_x >= GRID_W_L);
            end
            DIR_DOWN: begin
                cand_y   = cand_y + Y_ONE;
                off_grid = (cand_y >= GRID_H_L);
            end
            default: begin
                off_grid = (head_x_q == '0);
                cand_x   = cand_x - X_ONE;
            end
        endcase
    end

    assign next_xy    = {cand_x[XW-1:0], cand_y[YW-1:0]};
    assign hit_food   = (next_xy == {food_x, food_y});
    assign grow_c     = hit_food && ({1'b0, body_len} < MAX_LEN_L);
    // Without growth the tail leaves its cell, so it is excluded from the scan.
    assign scan_len_c = grow_c ? body_len : ((body_len == 8'd0) ? 8'd0 : body_len - 8'd1);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        nxt_d      = nxt_q;
        grow_d     = grow_q;
        eat_d      = eat_q;
        scan_n_d   = scan_n_q;
        scan_idx_d = scan_idx_q;
        init_cnt_d = init_cnt_q;
        cmp_vld_d  = (state_q == S_SCAN) && (scan_idx_q < scan_n_q);
        overrun_d  = overrun_q | (tick & busy);
        case (state_q)
            S_IDLE, S_DEAD: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    overrun_d = 1'b0;
                end
            end
            S_CLEAR: begin
                dir_d      = DIR_RIGHT;
                head_x_d   = START_X_L;
                head_y_d   = START_Y_L;
                init_cnt_d = 8'd0;
                state_d    = S_INIT;
            end
            S_INIT: begin
                init_cnt_d = init_cnt_q + 8'd1;
                if (init_cnt_q == INIT_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick) begin
                    if (dir_req != (dir_q ^ 2'b10)) dir_d = dir_req;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (off_grid) begin
                    state_d = S_DEAD;
                end else begin
                    nxt_d      = next_xy;
                    grow_d     = grow_c;
                    eat_d      = hit_food;
                    scan_n_d   = scan_len_c;
                    scan_idx_d = 8'd0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                // Data for the address issued last cycle arrives now; one extra
                // cycle after the final address drains the last comparison.
                if (cmp_vld_q && (scan_data == nxt_q)) begin
                    scan_idx_d = 8'd0;
                    state_d    = S_DEAD;
                end else if (scan_idx_q == scan_n_q) begin
                    scan_idx_d = 8'd0;
                    state_d    = S_COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + 8'd1;
                end
            end
            default: begin
                head_x_d = nxt_q[CW-1:YW];
                head_y_d = nxt_q[YW-1:0];
                state_d  = S_WAIT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dir_q      <= DIR_RIGHT;
            head_x_q   <= START_X_L;
            head_y_q   <= START_Y_L;
            nxt_q      <= '0;
            grow_q     <= 1'b0;
            eat_q      <= 1'b0;
            scan_n_q   <= 8'd0;
            scan_idx_q <= 8'd0;
            cmp_vld_q  <= 1'b0;
            init_cnt_q <= 8'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            nxt_q      <= nxt_d;
            grow_q     <= grow_d;
            eat_q      <= eat_d;
            scan_n_q   <= scan_n_d;
            scan_idx_q <= scan_idx_d;
            cmp_vld_q  <= cmp_vld_d;
            init_cnt_q <= init_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        body_din = '0;
        if (state_q == S_INIT)   body_din = {INIT_X0 + XW'(init_cnt_q), START_Y_L};
        if (state_q == S_COMMIT) body_din = nxt_q;
    end

    assign body_clr     = (state_q == S_CLEAR);
    assign body_push    = (state_q == S_INIT) || (state_q == S_COMMIT);
    assign body_pop     = (state_q == S_COMMIT) && !grow_q;
    assign food_eaten   = (state_q == S_COMMIT) && eat_q;
    assign step_done    = (state_q == S_COMMIT);
    assign busy         = !((state_q == S_IDLE) || (state_q == S_WAIT) || (state_q == S_DEAD));
    assign game_over    = (state_q == S_DEAD);
    assign tick_overrun = overrun_q;
    assign scan_addr    = scan_idx_q;
    assign head_x       = head_x_q;
    assign head_y       = head_y_q;

endmodule
